// File: rtl/rps_draw_sched.sv
// rps_draw_sched: redraws the user or computer rock/paper/scissors panel
// into the 160x120 frame buffer. One requester is served at a time over a
// shared bitmap ROM and a single plot port. The plot side runs one cycle
// behind the ROM address to absorb the ROM read latency.
`timescale 1ns/1ps
module rps_draw_sched #(
  parameter int          PANEL_W   = 80,
  parameter int          PANEL_H   = 120,
  parameter int          SCREEN_W  = 160,
  parameter int          USER_X0   = 80,
  parameter int          COMP_X0   = 0,
  parameter logic [2:0]  FG_COLOUR = 3'b010,
  parameter logic [2:0]  USER_BG   = 3'b000,
  parameter logic [2:0]  COMP_BG   = 3'b111
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        req_user,
  input  logic [1:0]  choice_user,
  input  logic        req_comp,
  input  logic [1:0]  choice_comp,
  output logic [14:0] rom_addr,
  output logic [1:0]  rom_sel,
  input  logic        rom_q,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        busy,
  output logic        done_user,
  output logic        done_comp
);

  typedef enum logic [1:0] {IDLE, DRAW, FLUSH, DONE} state_t;

  localparam logic [7:0] UX0    = 8'(USER_X0);
  localparam logic [7:0] CX0    = 8'(COMP_X0);
  localparam logic [7:0] PW     = 8'(PANEL_W);
  localparam logic [6:0] LAST_Y = 7'(PANEL_H - 1);

  state_t      state;
  logic        pend_user, pend_comp;
  logic [1:0]  choice_user_q, choice_comp_q;
  logic        last_comp;
  logic        panel_comp;
  logic [7:0]  x0, cx;
  logic [6:0]  cy;
  logic [7:0]  x_p1;
  logic [6:0]  y_p1;
  logic        vld_p1, comp_p1;
  logic        grant_user;
  logic [7:0]  grant_x0;
  logic [7:0]  x_last;

  // Frame-buffer address, computed in 16 bits and truncated to the ROM width.
  function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    logic [15:0] a;
    a = 16'(y) * 16'(SCREEN_W) + 16'(x);
    return a[14:0];
  endfunction

  // Choice 11 selects the paper bitmap, same as 10.
  function automatic logic [1:0] map_sel(input logic [1:0] c);
    return (c == 2'b11) ? 2'b10 : c;
  endfunction

  // Round-robin: with both pending, the panel not served last wins.
  assign grant_user = pend_user && (!pend_comp || last_comp);
  assign grant_x0   = grant_user ? UX0 : CX0;
  assign x_last     = x0 + PW - 8'd1;

  // Request capture, draw sequencing and the plot-side register stage.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      pend_user     <= 1'b0;
      pend_comp     <= 1'b0;
      choice_user_q <= 2'b00;
      choice_comp_q <= 2'b00;
      last_comp     <= 1'b1;
      panel_comp    <= 1'b0;
      x0            <= 8'd0;
      cx            <= 8'd0;
      cy            <= 7'd0;
      rom_addr      <= 15'd0;
      rom_sel       <= 2'b00;
      busy          <= 1'b0;
      done_user     <= 1'b0;
      done_comp     <= 1'b0;
      x_p1          <= 8'd0;
      y_p1          <= 7'd0;
      vld_p1        <= 1'b0;
      comp_p1       <= 1'b0;
    end else begin
      vld_p1    <= 1'b0;
      done_user <= 1'b0;
      done_comp <= 1'b0;

      case (state)
        IDLE: begin
          if (pend_user || pend_comp) begin
            state      <= DRAW;
            busy       <= 1'b1;
            panel_comp <= !grant_user;
            last_comp  <= !grant_user;
            x0         <= grant_x0;
            cx         <= grant_x0;
            cy         <= 7'd0;
            rom_addr   <= pix_addr(grant_x0, 7'd0);
            rom_sel    <= map_sel(grant_user ? choice_user_q : choice_comp_q);
            if (grant_user) pend_user <= 1'b0;
            else            pend_comp <= 1'b0;
          end
        end
        DRAW: begin
          // stage p1: coordinates of the address issued this cycle
          x_p1    <= cx;
          y_p1    <= cy;
          vld_p1  <= 1'b1;
          comp_p1 <= panel_comp;
          if (cx == x_last) begin
            if (cy == LAST_Y) begin
              state <= FLUSH;
            end else begin
              cx       <= x0;
              cy       <= cy + 7'd1;
              rom_addr <= pix_addr(x0, cy + 7'd1);
            end
          end else begin
            cx       <= cx + 8'd1;
            rom_addr <= pix_addr(cx + 8'd1, cy);
          end
        end
        FLUSH: begin
          state     <= DONE;
          busy      <= 1'b0;
          done_user <= !panel_comp;
          done_comp <= panel_comp;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // New requests override any clear from a grant in the same cycle.
      if (req_user) begin
        pend_user     <= 1'b1;
        choice_user_q <= choice_user;
      end
      if (req_comp) begin
        pend_comp     <= 1'b1;
        choice_comp_q <= choice_comp;
      end
    end
  end

  assign vga_x      = x_p1;
  assign vga_y      = y_p1;
  assign vga_plot   = vld_p1;
  assign vga_colour = !vld_p1 ? 3'b000 :
                      (rom_q ? (comp_p1 ? COMP_BG : USER_BG) : FG_COLOUR);

endmodule

// File: tb/tb_rps_draw_sched.sv
// Testbench for rps_draw_sched: expected plot/done events are queued as
// stimulus is issued; a monitor pops and compares them as the DUT emits.
`timescale 1ns/1ps
module tb_rps_draw_sched;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_user = 1'b0, req_comp = 1'b0;
  logic [1:0]  choice_user = 2'b00, choice_comp = 2'b00;
  logic        rom_q = 1'b0;
  logic [14:0] rom_addr;
  logic [1:0]  rom_sel;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot, busy, done_user, done_comp;

  rps_draw_sched dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n),
    .req_user(req_user), .choice_user(choice_user),
    .req_comp(req_comp), .choice_comp(choice_comp),
    .rom_addr(rom_addr), .rom_sel(rom_sel), .rom_q(rom_q),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .done_user(done_user), .done_comp(done_comp)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef logic [36:0] ev_t;  // {kind, x, y, colour, sel, addr}
  ev_t         exp_q[$];
  int          n_cmp = 0, n_bad = 0, n_done = 0;
  int          done_cyc[$];
  int          cyc = 0;
  logic [14:0] prev_addr = 15'd0;
  logic        prev_plot = 1'b0;

  // Bitmap content stand-in: a fixed bit pattern per address and bitmap.
  function automatic logic rom_fn(input logic [14:0] a, input logic [1:0] s);
    return a[0] ^ a[4] ^ a[7] ^ a[11] ^ (s == 2'b01) ^ (s[1] & a[2]);
  endfunction

  function automatic ev_t mk(input logic [1:0] k, input logic [7:0] x, input logic [6:0] y,
                             input logic [2:0] c, input logic [1:0] s, input logic [14:0] a);
    return {k, x, y, c, s, a};
  endfunction

  always @(posedge CLOCK_50) cyc <= cyc + 1;
  // One-cycle-latency ROM model
  always @(posedge CLOCK_50) rom_q <= rom_fn(rom_addr, rom_sel);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue the first n pixels of a panel pass, optionally followed by its done.
  task automatic push_pass(input bit comp, input logic [1:0] choice, input int n, input bit with_done);
    logic [1:0]  s;
    logic [7:0]  gx;
    logic [14:0] a;
    logic [2:0]  c;
    int          k;
    k = 0;
    s = (choice == 2'b11) ? 2'b10 : choice;
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 80; x++)
        if (k < n) begin
          gx = comp ? 8'(x) : 8'(80 + x);
          a  = 15'(y * 160 + int'(gx));
          c  = rom_fn(a, s) ? (comp ? 3'b111 : 3'b000) : 3'b010;
          exp_q.push_back(mk(2'd0, gx, 7'(y), c, s, a));
          k++;
        end
    if (with_done) exp_q.push_back(mk(comp ? 2'd2 : 2'd1, 8'd0, 7'd0, 3'd0, 2'd0, 15'd0));
  endtask

  // Monitor: every plot or done pulse is matched against the queue head.
  always @(negedge CLOCK_50) begin
    ev_t act, e;
    if (vga_plot || done_user || done_comp) begin
      if (vga_plot) act = mk(2'd0, vga_x, vga_y, vga_colour, rom_sel, prev_addr);
      else          act = mk(done_comp ? 2'd2 : 2'd1, 8'd0, 7'd0, 3'd0, 2'd0, 15'd0);
      if (!vga_plot) begin
        n_done++;
        done_cyc.push_back(cyc);
        check("done_follows_last_plot", 64'(prev_plot), 64'd1);
      end
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: got %0h expected none", act);
      end else begin
        e = exp_q.pop_front();
        check("event", 64'(act), 64'(e));
      end
    end
    prev_addr = rom_addr;
    prev_plot = vga_plot;
  end

  task automatic wait_done(input int target, input int budget, input string name);
    int i;
    i = 0;
    while (n_done < target && i < budget) begin
      @(posedge CLOCK_50);
      i++;
    end
    check(name, 64'(n_done >= target), 64'd1);
  endtask

  task automatic check_outs_zero(input string name);
    check(name, 64'({rom_addr, rom_sel, vga_x, vga_y, vga_colour, vga_plot,
                     busy, done_user, done_comp}), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, nd;

    // Reset state
    repeat (3) @(posedge CLOCK_50);
    #2 check_outs_zero("reset_outputs");
    @(negedge CLOCK_50) reset_n = 1'b1;
    @(posedge CLOCK_50);

    // Single user redraw, rock
    push_pass(1'b0, 2'b00, 9600, 1'b1);
    @(negedge CLOCK_50) begin req_user = 1'b1; choice_user = 2'b00; end
    @(posedge CLOCK_50);
    #2 req_user = 1'b0;
    c0 = cyc;
    check("busy_before_grant", 64'(busy), 64'd0);
    @(posedge CLOCK_50);
    #2 check("busy_after_grant", 64'(busy), 64'd1);
    check("first_rom_addr", 64'(rom_addr), 64'd80);
    check("rom_sel_rock", 64'(rom_sel), 64'd0);
    wait_done(1, 9700, "user_pass_done");
    check("user_done_cycle", 64'(done_cyc[0]), 64'(c0 + 9602));
    repeat (3) @(posedge CLOCK_50);

    // Reset between tests clears the last-grant history
    @(negedge CLOCK_50) reset_n = 1'b0;
    #2 check_outs_zero("reset_after_pass");
    @(negedge CLOCK_50) reset_n = 1'b1;
    @(posedge CLOCK_50);

    // Simultaneous requests: user (choice 11 -> paper) first, then computer
    push_pass(1'b0, 2'b11, 9600, 1'b1);
    push_pass(1'b1, 2'b00, 9600, 1'b1);
    @(negedge CLOCK_50) begin
      req_user = 1'b1; choice_user = 2'b11;
      req_comp = 1'b1; choice_comp = 2'b00;
    end
    @(posedge CLOCK_50);
    #2 begin req_user = 1'b0; req_comp = 1'b0; end
    wait_done(2, 9700, "tie_user_done");
    repeat (5002) @(posedge CLOCK_50);
    // Mid-pass re-request for the drawing panel; second request overwrites the first
    push_pass(1'b1, 2'b01, 9600, 1'b1);
    @(negedge CLOCK_50) begin req_comp = 1'b1; choice_comp = 2'b10; end
    @(negedge CLOCK_50) begin req_comp = 1'b1; choice_comp = 2'b01; end
    @(negedge CLOCK_50) req_comp = 1'b0;
    wait_done(4, 2 * 9700, "comp_redraw_done");
    repeat (3) @(posedge CLOCK_50);

    // Reset at pixel 3000 of a user pass with a computer request pending
    push_pass(1'b0, 2'b00, 3000, 1'b0);
    nd = n_done;
    @(negedge CLOCK_50) begin req_user = 1'b1; choice_user = 2'b00; end
    @(posedge CLOCK_50);
    #2 req_user = 1'b0;
    repeat (999) @(posedge CLOCK_50);
    @(negedge CLOCK_50) begin req_comp = 1'b1; choice_comp = 2'b10; end
    @(posedge CLOCK_50);
    #2 req_comp = 1'b0;
    repeat (2001) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    #2 reset_n = 1'b0;
    #1 check("abort_plot", 64'(vga_plot), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check_outs_zero("abort_outputs");
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50) reset_n = 1'b1;
    repeat (40) @(posedge CLOCK_50);
    #2 check("idle_after_abort_busy", 64'(busy), 64'd0);
    check("no_done_after_abort", 64'(n_done), 64'(nd));
    check("abort_queue_drained", 64'(exp_q.size()), 64'd0);

    // Requests held for 100 cycles: grants alternate user, comp, user
    push_pass(1'b0, 2'b10, 9600, 1'b1);
    push_pass(1'b1, 2'b01, 9600, 1'b1);
    push_pass(1'b0, 2'b10, 9600, 1'b1);
    nd = n_done;
    @(negedge CLOCK_50) begin
      req_user = 1'b1; choice_user = 2'b10;
      req_comp = 1'b1; choice_comp = 2'b01;
    end
    @(posedge CLOCK_50);
    #2 c0 = cyc;
    repeat (99) @(posedge CLOCK_50);
    #2 begin req_user = 1'b0; req_comp = 1'b0; end
    wait_done(nd + 3, 3 * 9700, "alternate_done");
    if (done_cyc.size() >= nd + 3) begin
      check("alt_done0_cycle", 64'(done_cyc[nd]),     64'(c0 + 9602));
      check("alt_done1_cycle", 64'(done_cyc[nd + 1]), 64'(c0 + 9602 + 9603));
      check("alt_done2_cycle", 64'(done_cyc[nd + 2]), 64'(c0 + 9602 + 2 * 9603));
    end
    repeat (20) @(posedge CLOCK_50);
    #2 check("final_idle_busy", 64'(busy), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
